// File: rtl/i2c_reg_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_reg_sequencer_if                                         |
// | Description : Command/response and byte-engine signals of the I2C register |
// |               sequencer, bundled for connection between the sequencer and  |
// |               its environment.                                             |
// |   master : sequencer side (takes commands, drives the i2c_master engine)   |
// |   slave  : environment side (issues commands, models the i2c_master)       |
// |   cmd_*  : command request and handshake                                   |
// |   rsp_*  : one-cycle response pulse with read data and error code          |
// |   i2c_*  : ena/addr/rw/data_wr to the engine, busy/data_rd/ack_error back  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface i2c_reg_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_dev_addr;
    logic [7:0]  cmd_reg_addr;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        i2c_ena;
    logic [6:0]  i2c_addr;
    logic        i2c_rw;
    logic [7:0]  i2c_data_wr;
    logic        i2c_busy;
    logic [7:0]  i2c_data_rd;
    logic        i2c_ack_error;

    modport master (
        input  cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_len, cmd_wdata,
        input  i2c_busy, i2c_data_rd, i2c_ack_error,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output i2c_ena, i2c_addr, i2c_rw, i2c_data_wr
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_len, cmd_wdata,
        output i2c_busy, i2c_data_rd, i2c_ack_error,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  i2c_ena, i2c_addr, i2c_rw, i2c_data_wr
    );
endinterface
`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_reg_sequencer                                            |
// | Description : Turns one register write/read command into a complete I2C    |
// |               transaction on an i2c_master byte engine, paced by the       |
// |               engine's busy edges, and returns one response.               |
// | Ports       : clk   - system clock (same as i2c_master)                    |
// |               reset - synchronous, active-high                             |
// |               bus   - i2c_reg_sequencer_if.master (command, response and   |
// |                       engine handshake signals)                            |
// | Parameters  : MAX_LEN        - max data bytes per command (bus sized for 4)|
// |               TIMEOUT_CYCLES - clk cycles allowed per command              |
// | Option      : I2C_SEQ_RETRY_EN - relaunch once after an address/register  |
// |               phase NACK                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_reg_sequencer #(
    parameter int MAX_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    i2c_reg_sequencer_if.master        bus
);
    localparam int C_TMO_W = ((TIMEOUT_CYCLES + 1) > (1 << 20)) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q;
    logic [3:0]          rise_cnt_q, rise_cnt_d;
    logic [C_TMO_W-1:0]  tmo_q, tmo_d;
    logic                rw_q, rw_d;
    logic [2:0]          len_q, len_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_err_q, rsp_err_d;
    logic                ena_q, ena_d;
    logic [6:0]          addr_q, addr_d;
    logic                i2c_rw_q, i2c_rw_d;
    logic [7:0]          data_wr_q, data_wr_d;
`ifdef I2C_SEQ_RETRY_EN
    logic [7:0]          reg_q, reg_d;
    logic                retried_q, retried_d;
`endif

    logic       w_rise;
    logic       w_fall;
    logic       w_bad_len;
    logic [3:0] w_rd_idx;

    assign w_rise    = bus.i2c_busy & ~busy_q;
    assign w_fall    = ~bus.i2c_busy & busy_q;
    assign w_bad_len = (bus.cmd_len == 3'd0) || (int'(bus.cmd_len) > MAX_LEN);
    // Read byte k completes on the fall that follows rise k+2 (rise 1 is the register byte).
    assign w_rd_idx  = rise_cnt_q - 4'd2;

    always_comb begin
        state_d     = state_q;
        rise_cnt_d  = rise_cnt_q;
        tmo_d       = tmo_q;
        rw_d        = rw_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ena_d       = ena_q;
        addr_d      = addr_q;
        i2c_rw_d    = i2c_rw_q;
        data_wr_d   = data_wr_q;
`ifdef I2C_SEQ_RETRY_EN
        reg_d       = reg_q;
        retried_d   = retried_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    rw_d        = bus.cmd_rw;
                    len_d       = bus.cmd_len;
                    wdata_d     = bus.cmd_wdata;
                    rise_cnt_d  = 4'd0;
                    tmo_d       = '0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 2'b00;
`ifdef I2C_SEQ_RETRY_EN
                    reg_d       = bus.cmd_reg_addr;
                    retried_d   = 1'b0;
`endif
                    if (w_bad_len) begin
                        rsp_err_d = 2'b11;
                        state_d   = S_RESP;
                    end else begin
                        ena_d     = 1'b1;
                        addr_d    = bus.cmd_dev_addr;
                        i2c_rw_d  = 1'b0;
                        data_wr_d = bus.cmd_reg_addr;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN, S_DRAIN: begin
                // Timeout pre-empts everything else in this cycle, including a busy edge.
                if (tmo_q == C_TMO_LAST) begin
                    rsp_err_d = 2'b10;
                    ena_d     = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (w_rise) begin
                        rise_cnt_d = rise_cnt_q + 4'd1;
                    end
                    if (w_fall && rw_q && (rise_cnt_q >= 4'd2) && (int'(w_rd_idx) < MAX_LEN)) begin
                        rsp_rdata_d[{w_rd_idx[1:0], 3'b000} +: 8] = bus.i2c_data_rd;
                    end
                    if (state_q == S_RUN) begin
                        // On rise n the engine has latched byte n-1; queue the next one
                        // or drop ena so it stops after the byte in flight.
                        if (w_rise) begin
                            if (!rw_q) begin
                                if (rise_cnt_q < {1'b0, len_q}) begin
                                    data_wr_d = wdata_q[{rise_cnt_q[1:0], 3'b000} +: 8];
                                end else if (rise_cnt_q == {1'b0, len_q}) begin
                                    ena_d   = 1'b0;
                                    state_d = S_DRAIN;
                                end
                            end else begin
                                if (rise_cnt_q == 4'd0) begin
                                    i2c_rw_d = 1'b1;  // direction change -> repeated START
                                end else if (rise_cnt_q == {1'b0, len_q}) begin
                                    ena_d   = 1'b0;
                                    state_d = S_DRAIN;
                                end
                            end
                        end
                        if (w_fall && bus.i2c_ack_error) begin
                            rsp_err_d = 2'b01;
                            ena_d     = 1'b0;
                            state_d   = S_DRAIN;
                        end
                    end else begin
                        if (w_fall && bus.i2c_ack_error) begin
                            rsp_err_d = 2'b01;
                        end
                        if (!bus.i2c_busy && !busy_q) begin
`ifdef I2C_SEQ_RETRY_EN
                            if ((rsp_err_q == 2'b01) && (rise_cnt_q <= 4'd1) && !retried_q) begin
                                retried_d  = 1'b1;
                                rise_cnt_d = 4'd0;
                                rsp_err_d  = 2'b00;
                                ena_d      = 1'b1;
                                i2c_rw_d   = 1'b0;
                                data_wr_d  = reg_q;
                                state_d    = S_RUN;
                            end else begin
                                state_d = S_RESP;
                            end
`else
                            state_d = S_RESP;
`endif
                        end
                    end
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Ready is withheld during the response pulse so a command there is not taken.
        cmd_ready_d = (state_d == S_IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            rise_cnt_q  <= 4'd0;
            tmo_q       <= '0;
            rw_q        <= 1'b0;
            len_q       <= 3'd0;
            wdata_q     <= 32'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 2'b00;
            ena_q       <= 1'b0;
            addr_q      <= 7'd0;
            i2c_rw_q    <= 1'b0;
            data_wr_q   <= 8'd0;
`ifdef I2C_SEQ_RETRY_EN
            reg_q       <= 8'd0;
            retried_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= bus.i2c_busy;
            rise_cnt_q  <= rise_cnt_d;
            tmo_q       <= tmo_d;
            rw_q        <= rw_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ena_q       <= ena_d;
            addr_q      <= addr_d;
            i2c_rw_q    <= i2c_rw_d;
            data_wr_q   <= data_wr_d;
`ifdef I2C_SEQ_RETRY_EN
            reg_q       <= reg_d;
            retried_q   <= retried_d;
`endif
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.i2c_ena     = ena_q;
    assign bus.i2c_addr    = addr_q;
    assign bus.i2c_rw      = i2c_rw_q;
    assign bus.i2c_data_wr = data_wr_q;
endmodule
`default_nettype wire

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

- Register-access controller that sits in front of the `i2c_master` byte engine and turns one command into a complete I2C transaction.
- Supported commands:
  - multi-byte register write: START, address+W, register, data…, STOP.
  - multi-byte register read: START, address+W, register, repeated START, address+R, data…, STOP.
- It drives the master's `ena/addr/rw/data_wr` handshake from the master's `busy` edges, collects read bytes and reports a single response with an error code.

## Interface

Parameters:
- `MAX_LEN`, default 4: maximum data bytes per command. The 32-bit data buses assume 4.
- `TIMEOUT_CYCLES`, default 1000000: `clk` cycles allowed per command before abort.

Ports:
- `clk` in 1: system clock, the same clock as `i2c_master`.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE. A command is accepted when `cmd_valid && cmd_ready`.
- `cmd_rw` in 1: 0 = register write, 1 = register read.
- `cmd_dev_addr` in 7: 7-bit slave address.
- `cmd_reg_addr` in 8: register/pointer byte.
- `cmd_len` in 3: number of data bytes. Legal range is 1..MAX_LEN.
- `cmd_wdata` in 32: write bytes. Byte k is `[8k+7:8k]` and byte 0 is sent first.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: read bytes in the same packing as `cmd_wdata`. Unused bytes are 0. The value is 0 for writes.
- `rsp_err` out 2: response code.
  - 00 = ok
  - 01 = NACK
  - 10 = timeout
  - 11 = bad length
- `i2c_ena` out 1, `i2c_addr` out 7, `i2c_rw` out 1, `i2c_data_wr` out 8: drive the master.
- `i2c_busy` in 1, `i2c_data_rd` in 8, `i2c_ack_error` in 1: from the master.

## Operation

- Reset values of all outputs:
  - `cmd_ready`=0 during reset and 1 from the first cycle after reset.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00.
  - `i2c_ena`=0, `i2c_addr`=0, `i2c_rw`=0, `i2c_data_wr`=0.
- `busy_q` registers `i2c_busy` once. Edges are derived from it:
  - rise = `i2c_busy & ~busy_q`
  - fall = `~i2c_busy & busy_q`
- `rise_cnt` (4 bits) counts busy rises per command and clears on acceptance.
- State machine:
  - **IDLE**: `cmd_ready`=1. On acceptance, latch the command.
    - If `cmd_len`==0 or `cmd_len`>MAX_LEN, go to RESP with code 11. No bus activity occurs.
    - Otherwise drive `i2c_ena`=1, `i2c_addr`=dev, `i2c_rw`=0, `i2c_data_wr`=reg, and go to RUN.
  - **RUN**, write command: on rise n (n≥1, meaning byte n−1 is latched by the master):
    - if n ≤ len, set `i2c_data_wr` = wdata byte n−1;
    - if n == len+1, clear `i2c_ena` and go to DRAIN.
  - **RUN**, read command:
    - On rise 1, set `i2c_rw`=1, which causes a repeated START.
    - On rise n (n≥2), if n == len+1, clear `i2c_ena` and go to DRAIN.
    - On each fall where `rise_cnt`≥2, store `i2c_data_rd` into byte `rise_cnt`−2. The same applies in DRAIN.
  - **NACK**: if `i2c_ack_error`=1 on any fall in RUN, set code 01, clear `i2c_ena` and go to DRAIN. Remaining bytes are not sent.
  - **DRAIN**: wait for `i2c_busy`=0 with `busy_q`=0, then go to RESP. A final read byte is captured on the fall seen here. `i2c_ack_error` sampled at that fall also sets code 01.
  - **RESP**: pulse `rsp_valid` for one cycle with `rsp_rdata` and `rsp_err`, then go to IDLE.
- Timeout:
  - A 20-bit-minimum counter runs from acceptance through DRAIN.
  - Reaching TIMEOUT_CYCLES forces code 10, `i2c_ena`=0, and goes straight to RESP. It does not wait for busy.
  - Timeout overrides NACK.
- `rsp_rdata` and `rsp_err` hold their values until the next RESP.
- The response buffers are cleared at acceptance.

## Timing

- `i2c_ena` rises on the cycle after acceptance.
- Master-facing updates are registered in the cycle after the detected busy edge. That is at most 2 `clk` cycles after the `i2c_busy` transition, well inside the master's quarter-SCL window.
- A bad-length response has `rsp_valid` exactly 2 cycles after acceptance: IDLE→RESP→pulse.
- `cmd_ready` is 0 from the cycle after acceptance until the cycle after `rsp_valid`.
- A command presented in the same cycle as `rsp_valid` is not accepted.
- Simultaneous rise and timeout in one cycle: timeout wins and no master signal other than `i2c_ena`=0 changes.
- Reset asserted mid-transaction: on the next edge all outputs take their reset values and the state is IDLE. No response is issued. The master completes or stalls on its own.

## Configuration

- `I2C_SEQ_RETRY_EN` defined:
  - A command ending in DRAIN with code 01 and `rise_cnt`≤1 (NACK on the address or register phase) is re-launched once from IDLE-launch, with no handshake and the counters cleared.
  - The timeout counter is not reset on re-launch.
  - A second NACK reports 01.
- `I2C_SEQ_RETRY_EN` undefined: every NACK is reported immediately. Retry logic is absent.

## Test plan

- Write, dev 0x50, reg 0x10, len 2, wdata 0x00005AA5, ACKing slave model:
  - master sees bytes 0x10, 0xA5, 0x5A with rw=0, then STOP;
  - `rsp_err`=00, `rsp_rdata`=0.
- Read, dev 0x68, reg 0x75, len 3, slave returns 0x11, 0x22, 0x33:
  - repeated START after the register byte;
  - `rsp_rdata`=0x00332211, `rsp_err`=00.
- Slave NACKs address 0x21:
  - `rsp_err`=01;
  - with retry, exactly two address phases occur; without retry, one.
- `cmd_len`=0, then `cmd_len`=5:
  - `rsp_err`=11 with `rsp_valid` 2 cycles after acceptance;
  - `i2c_ena` never asserts.
- TIMEOUT_CYCLES=100 with `i2c_busy` held 0:
  - `rsp_err`=10 on cycle 101 after acceptance;
  - `i2c_ena`=0 on the following cycle.
- `reset` pulsed after the 2nd read byte:
  - outputs return to their reset values on the next edge;
  - no `rsp_valid`;
  - the next command completes with code 00.
